gnrc_fwft_fifo_lvl: RTL and testbench
=====================================

Name: gnrc_fwft_fifo_lvl

Overview:
Synchronous first-word-fall-through FIFO for arbitrary (non power-of-two) depth, with optional empty-bypass.
Adds the following to the basic FWFT FIFO:
- registered fill level;
- runtime-programmable almost-full and almost-empty flags (registered);
- sticky overflow and underflow error flags.
Used as the standard shallow elastic buffer between pipeline stages that need back-pressure hysteresis and error telemetry. Storage is zero-latency-read register/distributed RAM.

Parameters:
DW, 32, data width, >=1
DP, 8, depth in entries, >=2, any integer (pointers wrap at DP-1)
BYPASS, 0, {0,1}; 1 = when empty, data_i drives data_o combinationally
CW, $clog2(DP+1), level/threshold width (derived, do not override)

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  reset, asynchronous, active-low
flush_i  in  1  synchronous clear of all registered state (pointers, count, flags, sticky errors)
data_i  in  DW  write data
wen_i  in  1  push request
ren_i  in  1  pop request
afull_thr_i  in  CW  almost-full threshold, quasi-static
aempty_thr_i  in  CW  almost-empty threshold, quasi-static
full_o  out  1  count_q==DP
empty_o  out  1  no readable data (see BYPASS)
data_o  out  DW  head entry (FWFT)
usage_o  out  CW  registered entry count
afull_o  out  1  registered: count >= afull_thr_i
aempty_o  out  1  registered: count <= aempty_thr_i
ovf_o  out  1  sticky: push attempted while full
udf_o  out  1  sticky: pop attempted while empty

Behaviour:
- Reset/flush values: wptr=rptr=0, count_q=0, usage_o=0, full_o=0, afull_o=0, aempty_o=1, ovf_o=udf_o=0. empty_o=1 (BYPASS=1: empty_o=~wen_i). flush_i has priority over push/pop in the same cycle.
- Push accept: acc_w = wen_i & ~full_o. Pop accept: acc_r = ren_i & ~empty_o.
- A push while full is dropped; it never uses a same-cycle pop slot. A pop while empty returns no data.
- Accepted push writes mem[wptr]; wptr <= (wptr==DP-1)?0:wptr+1. Accepted pop advances rptr identically.
- count_d = count_q + acc_w - acc_r. A simultaneous push and pop leaves the count unchanged. Count never exceeds DP and never underflows.
- FWFT: data_o = mem[rptr] combinationally; valid whenever count_q>0. Write-to-output latency is 1 cycle (BYPASS=0).
- BYPASS=1 and count_q==0:
  - empty_o=~wen_i and data_o=data_i.
  - wen_i&ren_i in the same cycle: data passes through and no pointer or count changes.
  - wen_i&~ren_i: normal write.
  - Bypass path is unaffected by flush_i.
- BYPASS=0: data_o is don't-care when empty_o=1. Bench must not check it.
- Level flags are registered from count_d: afull_q <= (count_d >= afull_thr_i) and aempty_q <= (count_d <= aempty_thr_i). They are therefore coherent with usage_o in the same cycle.
- Threshold edge values: afull_thr_i=0 gives afull_o=1 after the first clock. aempty_thr_i>=DP gives aempty_o constantly 1.
- Sticky errors:
  - ovf_q <= ovf_q | (wen_i & full_o).
  - udf_q <= udf_q | (ren_i & empty_o).
  - Cleared only by reset/flush.
  - BYPASS pass-through is not an underflow.
- Reset mid-operation: async clear of all state on the rst_ni falling edge. Memory contents are not reset and are don't-care.

Decomposition:
- Package gnrc_fifo_pkg: function cnt_width(DP) = $clog2(DP+1); function ptr_wrap(ptr, DP).
- Sub-module gnrc_fifo_ptr: pointer register with wrap at DP-1, enable and flush. Instantiated twice (write and read).
- Storage: gnrc_dist_dpram (IBUF=0, OBUF=0).
- Flags and count live in the top module.

Test Plan:
1. DW=8, DP=5, BYPASS=0: push 0x11..0x15 -> full_o=1, usage_o=5. Then push 0xAA -> dropped, ovf_o=1. Pop 5 -> data 0x11..0x15 in order, empty_o=1.
2. Wrap: 12 cycles of alternating push/pop through DP=5 -> data order preserved, usage_o stays ≤1, no errors.
3. Thresholds afull=4, aempty=1: fill 0→5 -> aempty_o falls the cycle usage_o becomes 2, afull_o rises the cycle usage_o becomes 4. Drain reverses both.
4. BYPASS=1, empty, push 0x5A with pop -> data_o=0x5A same cycle, empty_o=0, usage_o stays 0, udf_o=0.
5. Pop on empty with BYPASS=0 -> udf_o=1 and stays set. flush_i -> udf_o=0, usage_o=0, aempty_o=1.
6. Assert rst_ni low with 3 entries held -> outputs at reset values immediately. After release, push 0x77 -> data_o=0x77 next cycle.

Source files
------------

// File: rtl/gnrc_fifo_pkg.sv
// Shared helpers for the generic FIFO family: level width and pointer wrap.
package gnrc_fifo_pkg;

    function automatic int unsigned cnt_width(input int unsigned dp);
        return $clog2(dp + 1);
    endfunction

    // Depth need not be a power of two, so pointers wrap explicitly at dp-1.
    function automatic int unsigned ptr_wrap(input int unsigned ptr, input int unsigned dp);
        return (ptr == dp - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/gnrc_dist_dpram.sv
// Distributed dual-port RAM: one write port, one asynchronous read port,
// optional input/output register stages.
module gnrc_dist_dpram #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3,
    parameter bit          IBUF  = 1'b0,
    parameter bit          OBUF  = 1'b0
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem [DEPTH];
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;

    generate
        if (IBUF) begin : g_ibuf
            always_ff @(posedge clk_i) begin
                we    <= we_i;
                waddr <= waddr_i;
                wdata <= wdata_i;
            end
        end else begin : g_no_ibuf
            assign we    = we_i;
            assign waddr = waddr_i;
            assign wdata = wdata_i;
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr_i];

    generate
        if (OBUF) begin : g_obuf
            always_ff @(posedge clk_i) begin
                rdata_o <= rdata;
            end
        end else begin : g_no_obuf
            assign rdata_o = rdata;
        end
    endgenerate

endmodule

// File: rtl/gnrc_fifo_ptr.sv
// FIFO pointer register: advances on en_i, wraps at DP-1, cleared by flush.
module gnrc_fifo_ptr
    import gnrc_fifo_pkg::*;
#(
    parameter int unsigned DP = 8,
    parameter int unsigned PW = (DP > 1) ? $clog2(DP) : 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          flush_i,
    input  logic          en_i,
    output logic [PW-1:0] ptr_o
);

    logic [PW-1:0] ptr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (flush_i) begin
            ptr_q <= '0;
        end else if (en_i) begin
            ptr_q <= PW'(ptr_wrap(32'(ptr_q), DP));
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/gnrc_fwft_fifo_lvl.sv
// First-word-fall-through FIFO with registered level, programmable
// almost-full/almost-empty flags, sticky overflow/underflow and optional bypass.
module gnrc_fwft_fifo_lvl
    import gnrc_fifo_pkg::*;
#(
    parameter int unsigned DW     = 32,
    parameter int unsigned DP     = 8,
    parameter bit          BYPASS = 1'b0,
    parameter int unsigned CW     = cnt_width(DP)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          flush_i,
    input  logic [DW-1:0] data_i,
    input  logic          wen_i,
    input  logic          ren_i,
    input  logic [CW-1:0] afull_thr_i,
    input  logic [CW-1:0] aempty_thr_i,
    output logic          full_o,
    output logic          empty_o,
    output logic [DW-1:0] data_o,
    output logic [CW-1:0] usage_o,
    output logic          afull_o,
    output logic          aempty_o,
    output logic          ovf_o,
    output logic          udf_o
);

    localparam int unsigned PW = $clog2(DP);

    logic [CW-1:0] count_q, count_d;
    logic          afull_q, aempty_q, ovf_q, udf_q;
    logic [PW-1:0] wptr, rptr;
    logic [DW-1:0] mem_rdata;
    logic          is_empty, acc_w, acc_r, passthru, wr_en, rd_en;

    assign is_empty = (count_q == '0);
    assign full_o   = (count_q == CW'(DP));
    assign empty_o  = BYPASS ? (is_empty & ~wen_i) : is_empty;
    assign data_o   = (BYPASS && is_empty) ? data_i : mem_rdata;

    assign acc_w = wen_i & ~full_o;
    assign acc_r = ren_i & ~empty_o;

    // A push+pop on an empty bypass FIFO is a pure pass-through: storage untouched.
    assign passthru = BYPASS & is_empty & wen_i & ren_i;
    assign wr_en    = acc_w & ~passthru;
    assign rd_en    = acc_r & ~passthru;

    always_comb begin
        count_d = count_q;
        if (wr_en && !rd_en) begin
            count_d = count_q + CW'(1);
        end else if (rd_en && !wr_en) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q  <= '0;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else if (flush_i) begin
            count_q  <= '0;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            count_q  <= count_d;
            afull_q  <= (count_d >= afull_thr_i);
            aempty_q <= (count_d <= aempty_thr_i);
            ovf_q    <= ovf_q | (wen_i & full_o);
            udf_q    <= udf_q | (ren_i & empty_o);
        end
    end

    assign usage_o  = count_q;
    assign afull_o  = afull_q;
    assign aempty_o = aempty_q;
    assign ovf_o    = ovf_q;
    assign udf_o    = udf_q;

    gnrc_fifo_ptr #(
        .DP (DP),
        .PW (PW)
    ) u_wptr (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .en_i    (wr_en),
        .ptr_o   (wptr)
    );

    gnrc_fifo_ptr #(
        .DP (DP),
        .PW (PW)
    ) u_rptr (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .en_i    (rd_en),
        .ptr_o   (rptr)
    );

    gnrc_dist_dpram #(
        .DW    (DW),
        .DEPTH (DP),
        .AW    (PW),
        .IBUF  (1'b0),
        .OBUF  (1'b0)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (wr_en),
        .waddr_i (wptr),
        .wdata_i (data_i),
        .raddr_i (rptr),
        .rdata_o (mem_rdata)
    );

endmodule

// File: tb/tb_gnrc_fwft_fifo_lvl.sv
// Bench for gnrc_fwft_fifo_lvl: a non-bypass and a bypass instance share
// stimulus; each is checked every cycle against a circular-buffer model.
module tb_gnrc_fwft_fifo_lvl;

    localparam int DW = 8;
    localparam int DP = 5;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          flush = 1'b0;
    logic          wen = 1'b0;
    logic          ren = 1'b0;
    logic [DW-1:0] din = '0;
    logic [CW-1:0] athr = 3'd4;
    logic [CW-1:0] ethr = 3'd1;

    logic          full_w   [2];
    logic          empty_w  [2];
    logic          afull_w  [2];
    logic          aempty_w [2];
    logic          ovf_w    [2];
    logic          udf_w    [2];
    logic [DW-1:0] data_w   [2];
    logic [CW-1:0] usage_w  [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    gnrc_fwft_fifo_lvl #(.DW(DW), .DP(DP), .BYPASS(1'b0)) dut0 (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush), .data_i(din),
        .wen_i(wen), .ren_i(ren), .afull_thr_i(athr), .aempty_thr_i(ethr),
        .full_o(full_w[0]), .empty_o(empty_w[0]), .data_o(data_w[0]),
        .usage_o(usage_w[0]), .afull_o(afull_w[0]), .aempty_o(aempty_w[0]),
        .ovf_o(ovf_w[0]), .udf_o(udf_w[0])
    );

    gnrc_fwft_fifo_lvl #(.DW(DW), .DP(DP), .BYPASS(1'b1)) dut1 (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush), .data_i(din),
        .wen_i(wen), .ren_i(ren), .afull_thr_i(athr), .aempty_thr_i(ethr),
        .full_o(full_w[1]), .empty_o(empty_w[1]), .data_o(data_w[1]),
        .usage_o(usage_w[1]), .afull_o(afull_w[1]), .aempty_o(aempty_w[1]),
        .ovf_o(ovf_w[1]), .udf_o(udf_w[1])
    );

    // Behavioural model: stored entries as a circular buffer (head + count).
    logic [DW-1:0] mm [2][DP];
    int  cnt_m [2] = '{0, 0};
    int  hd_m  [2] = '{0, 0};
    bit  af_m  [2] = '{0, 0};
    bit  ae_m  [2] = '{1, 1};
    bit  ov_m  [2] = '{0, 0};
    bit  ud_m  [2] = '{0, 0};

    task automatic chk(input string nm, input int b, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d @%0t: got %0h, expected %0h", nm, b, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            cnt_m[b] = 0; hd_m[b] = 0;
            af_m[b] = 1'b0; ae_m[b] = 1'b1;
            ov_m[b] = 1'b0; ud_m[b] = 1'b0;
        end
    endtask

    function automatic bit exp_empty(input int b);
        return (cnt_m[b] == 0) && !(b == 1 && wen);
    endfunction

    task automatic model_step();
        bit push, pop;
        if (flush) begin
            model_reset();
            return;
        end
        for (int b = 0; b < 2; b++) begin
            if (wen && cnt_m[b] == DP) ov_m[b] = 1'b1;
            if (ren && exp_empty(b))   ud_m[b] = 1'b1;
            push = wen && (cnt_m[b] < DP) && !(b == 1 && cnt_m[b] == 0 && ren);
            pop  = ren && (cnt_m[b] > 0);
            if (pop) begin
                hd_m[b] = (hd_m[b] + 1) % DP;
                cnt_m[b]--;
            end
            if (push) begin
                mm[b][(hd_m[b] + cnt_m[b]) % DP] = din;
                cnt_m[b]++;
            end
            af_m[b] = (cnt_m[b] >= int'(athr));
            ae_m[b] = (cnt_m[b] <= int'(ethr));
        end
    endtask

    task automatic model_compare();
        for (int b = 0; b < 2; b++) begin
            chk("full",   b, 32'(full_w[b]),   32'(cnt_m[b] == DP));
            chk("empty",  b, 32'(empty_w[b]),  32'(exp_empty(b)));
            chk("usage",  b, 32'(usage_w[b]),  32'(cnt_m[b]));
            chk("afull",  b, 32'(afull_w[b]),  32'(af_m[b]));
            chk("aempty", b, 32'(aempty_w[b]), 32'(ae_m[b]));
            chk("ovf",    b, 32'(ovf_w[b]),    32'(ov_m[b]));
            chk("udf",    b, 32'(udf_w[b]),    32'(ud_m[b]));
            if (!exp_empty(b)) begin
                chk("data", b, 32'(data_w[b]),
                    32'((b == 1 && cnt_m[b] == 0) ? din : mm[b][hd_m[b]]));
            end
        end
    endtask

    always @(posedge clk) begin
        if (!rst_ni) model_reset();
        else         model_step();
    end

    always @(negedge clk) begin
        if (!rst_ni) model_reset();
        model_compare();
    end

    task automatic cyc(input bit w, input bit r, input logic [DW-1:0] d);
        wen = w; ren = r; din = d;
        @(posedge clk);
        #1;
        wen = 1'b0; ren = 1'b0; flush = 1'b0;
        #1;
    endtask

    initial begin
        int pw;
        bit w, r;

        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;
        #1;
        chk("rst_usage",  0, 32'(usage_w[0]),  32'd0);
        chk("rst_empty",  0, 32'(empty_w[0]),  32'd1);
        chk("rst_aempty", 0, 32'(aempty_w[0]), 32'd1);
        chk("rst_afull",  0, 32'(afull_w[0]),  32'd0);
        chk("rst_full",   0, 32'(full_w[0]),   32'd0);

        // Fill to full with level-flag tracking (thresholds afull=4, aempty=1).
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 8'(8'h11 + i));
            chk("fill_usage",  0, 32'(usage_w[0]),  32'(i + 1));
            chk("fill_aempty", 0, 32'(aempty_w[0]), 32'(i + 1 <= 1));
            chk("fill_afull",  0, 32'(afull_w[0]),  32'(i + 1 >= 4));
        end
        chk("full_flag", 0, 32'(full_w[0]), 32'd1);
        cyc(1'b1, 1'b0, 8'hAA);
        chk("ovf_set",    0, 32'(ovf_w[0]),   32'd1);
        chk("ovf_set",    1, 32'(ovf_w[1]),   32'd1);
        chk("ovf_usage",  0, 32'(usage_w[0]), 32'd5);
        for (int i = 0; i < 5; i++) begin
            chk("drain_data", 0, 32'(data_w[0]), 32'(8'h11 + i));
            cyc(1'b0, 1'b1, 8'h00);
            chk("drain_aempty", 0, 32'(aempty_w[0]), 32'(4 - i <= 1));
            chk("drain_afull",  0, 32'(afull_w[0]),  32'(4 - i >= 4));
        end
        chk("drain_empty", 0, 32'(empty_w[0]), 32'd1);
        chk("drain_udf",   0, 32'(udf_w[0]),   32'd0);

        // Alternating push/pop across the pointer wrap.
        for (int i = 0; i < 12; i++) begin
            if (i % 2 == 0) begin
                cyc(1'b1, 1'b0, 8'(8'h30 + i / 2));
            end else begin
                chk("wrap_data", 0, 32'(data_w[0]), 32'(8'h30 + i / 2));
                cyc(1'b0, 1'b1, 8'h00);
            end
            chk("wrap_usage_le1", 0, 32'(usage_w[0] <= 3'd1), 32'd1);
        end
        chk("wrap_udf", 0, 32'(udf_w[0]), 32'd0);

        // Underflow is sticky until flush.
        cyc(1'b0, 1'b1, 8'h00);
        chk("udf_set", 0, 32'(udf_w[0]), 32'd1);
        cyc(1'b0, 1'b0, 8'h00);
        chk("udf_hold", 0, 32'(udf_w[0]), 32'd1);
        flush = 1'b1;
        cyc(1'b0, 1'b0, 8'h00);
        chk("flush_udf",    0, 32'(udf_w[0]),    32'd0);
        chk("flush_ovf",    0, 32'(ovf_w[0]),    32'd0);
        chk("flush_usage",  0, 32'(usage_w[0]),  32'd0);
        chk("flush_aempty", 0, 32'(aempty_w[0]), 32'd1);

        // Bypass pass-through on empty.
        wen = 1'b1; ren = 1'b1; din = 8'h5A;
        #1;
        chk("byp_data",  1, 32'(data_w[1]),  32'h5A);
        chk("byp_empty", 1, 32'(empty_w[1]), 32'd0);
        @(posedge clk);
        #1;
        wen = 1'b0; ren = 1'b0;
        #1;
        chk("byp_usage", 1, 32'(usage_w[1]), 32'd0);
        chk("byp_udf",   1, 32'(udf_w[1]),   32'd0);
        chk("nobyp_usage", 0, 32'(usage_w[0]), 32'd1);
        chk("nobyp_udf",   0, 32'(udf_w[0]),   32'd1);
        flush = 1'b1;
        cyc(1'b0, 1'b0, 8'h00);

        // Threshold edge values.
        athr = 3'd0; ethr = 3'd5;
        flush = 1'b1;
        cyc(1'b0, 1'b0, 8'h00);
        chk("thr0_after_flush", 0, 32'(afull_w[0]), 32'd0);
        cyc(1'b0, 1'b0, 8'h00);
        chk("thr0_afull", 0, 32'(afull_w[0]), 32'd1);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(i));
        chk("thr_dp_aempty", 0, 32'(aempty_w[0]), 32'd1);
        athr = 3'd4; ethr = 3'd1;
        flush = 1'b1;
        cyc(1'b0, 1'b0, 8'h00);

        // Asynchronous reset with entries held.
        for (int i = 1; i <= 3; i++) cyc(1'b1, 1'b0, 8'(i));
        chk("pre_rst_usage", 0, 32'(usage_w[0]), 32'd3);
        rst_ni = 1'b0;
        #1;
        chk("arst_usage",  0, 32'(usage_w[0]),  32'd0);
        chk("arst_empty",  0, 32'(empty_w[0]),  32'd1);
        chk("arst_full",   0, 32'(full_w[0]),   32'd0);
        chk("arst_aempty", 0, 32'(aempty_w[0]), 32'd1);
        chk("arst_afull",  0, 32'(afull_w[0]),  32'd0);
        @(posedge clk);
        #1 rst_ni = 1'b1;
        #1;
        cyc(1'b1, 1'b0, 8'h77);
        chk("post_rst_data",  0, 32'(data_w[0]),  32'h77);
        chk("post_rst_data",  1, 32'(data_w[1]),  32'h77);
        chk("post_rst_usage", 0, 32'(usage_w[0]), 32'd1);

        // Randomized traffic with varying fill bias, flushes, resets, thresholds.
        pw = 50;
        for (int n = 0; n < 3000; n++) begin
            if (n % 100 == 0) pw = int'($urandom_range(15, 85));
            if (n % 200 == 0) begin
                athr = 3'($urandom_range(0, 7));
                ethr = 3'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 499) == 0) begin
                rst_ni = 1'b0;
                @(posedge clk);
                #1 rst_ni = 1'b1;
                #1;
            end else begin
                flush = ($urandom_range(0, 63) == 0);
                w = (int'($urandom_range(0, 99)) < pw);
                r = (int'($urandom_range(0, 99)) < 100 - pw);
                cyc(w, r, 8'($urandom));
            end
        end

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
